// File: rtl/gcd_dispatch.sv
// Request FIFO, issue sequencer and result holder in front of the gcd core.
// Optional GCD_DISPATCH_STATS_EN adds a 16-bit completed-result counter port.
module gcd_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  output logic             core_valid_o,
  output logic [WIDTH-1:0] core_a_o,
  output logic [WIDTH-1:0] core_b_o,
  input  logic [WIDTH-1:0] core_gcd_i,
  input  logic             core_valid_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_gcd_o,
  output logic             res_bypass_o
`ifdef GCD_DISPATCH_STATS_EN
  ,
  output logic [15:0]      stat_done_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   fifo_a [DEPTH];
  logic [WIDTH-1:0]   fifo_b [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               ready_q;
  logic               push, pop, head_zero;
  logic [WIDTH-1:0]   head_a, head_b;
  logic [WIDTH-1:0]   core_a_q, core_b_q, res_gcd_q;
  logic               res_bypass_q;

  assign push      = req_valid_i && ready_q;
  assign head_a    = fifo_a[rd_ptr_q];
  assign head_b    = fifo_b[rd_ptr_q];
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign count_d   = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_a[wr_ptr_q] <= req_a_i;
      fifo_b[wr_ptr_q] <= req_b_i;
    end
  end

  // Ready is a registered not-full flag, so a pop only frees space from the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != (PTR_W+1)'(DEPTH));
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = head_zero ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_valid_i) state_d = S_RESP;
      S_RESP:  if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Zero operands never reach the core: x|0 = x and 0|0 = 0 give the gcd directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      core_a_q     <= '0;
      core_b_q     <= '0;
      res_gcd_q    <= '0;
      res_bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pop) begin
        if (head_zero) begin
          res_gcd_q    <= head_a | head_b;
          res_bypass_q <= 1'b1;
        end else begin
          core_a_q <= head_a;
          core_b_q <= head_b;
        end
      end
      if (state_q == S_WAIT && core_valid_i) begin
        res_gcd_q    <= core_gcd_i;
        res_bypass_q <= 1'b0;
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign core_valid_o = (state_q == S_ISSUE);
  assign core_a_o     = core_a_q;
  assign core_b_o     = core_b_q;
  assign res_valid_o  = (state_q == S_RESP);
  assign res_gcd_o    = res_gcd_q;
  assign res_bypass_o = res_bypass_q;

`ifdef GCD_DISPATCH_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) stat_q <= '0;
    else if (res_valid_o && res_ready_i) stat_q <= stat_q + 16'd1;
  end

  assign stat_done_o = stat_q;
`endif

endmodule

// File: doc/gcd_dispatch.md
# gcd_dispatch

Request front-end and result collector for the `gcd` core.
- Upstream side: accepts operand pairs over a ready/valid interface and buffers them in a small FIFO.
- Core side: issues one pair at a time to the core's `valid_i` / `a_i` / `b_i` pins and holds the operands stable while the core computes.
- Downstream side: captures `gcd_o` on `valid_o` and presents it on a back-pressured result interface.
- Zero operands would stall the core's subtract loop forever, so they bypass the core.

## Interface
- `WIDTH`, 8, operand/result width; must match the core's `WIDTH`.
- `DEPTH`, 4, request FIFO entries; power of two, ≥ 2.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high.
- `req_valid_i`  in  1  request offered.
- `req_ready_o`  out  1  request accepted this cycle when `req_valid_i` is also high.
- `req_a_i`, `req_b_i`  in  WIDTH  operands.
- `core_valid_o`  out  1  to core `valid_i`.
- `core_a_o`, `core_b_o`  out  WIDTH  to core `a_i` / `b_i`.
- `core_gcd_i`  in  WIDTH  from core `gcd_o`.
- `core_valid_i`  in  1  from core `valid_o`.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  downstream accepts.
- `res_gcd_o`  out  WIDTH  result.
- `res_bypass_o`  out  1  result was produced without the core (a zero operand).

## Operation
- **FIFO**
  - Push when `req_valid_i && req_ready_o`.
  - `req_ready_o = !full`, a registered-flag function only; it never depends on the same-cycle pop.
  - A pop frees space visible from the next cycle.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - FIFO empty: stay in IDLE.
  - FIFO non-empty, head has both operands nonzero: pop, load the head into the issue registers, go to ISSUE.
  - FIFO non-empty, head has either operand zero: pop, set `res_gcd_o = head_a | head_b`, set `res_bypass_o = 1`, go to RESP. This gives gcd(x,0)=x and gcd(0,0)=0.
- **ISSUE**
  - `core_valid_o = 1` for exactly this one cycle.
  - Go to WAIT.
- **WAIT**
  - `core_a_o` / `core_b_o` stay equal to the issue registers throughout ISSUE and WAIT, because the core samples its operands one cycle after `valid_i`.
  - On `core_valid_i`: register `core_gcd_i` into `res_gcd_o`, set `res_bypass_o = 0`, go to RESP.
- **RESP**
  - `res_valid_o = 1`.
  - `res_gcd_o` and `res_bypass_o` are held stable until `res_ready_i`.
  - On handshake, go to IDLE.
- Only one request is outstanding at the core at any time. `core_valid_i` outside WAIT is ignored.
- `res_valid_o` is a registered output decoded from state RESP.
- `core_a_o` / `core_b_o` are registers. They keep their last value outside ISSUE/WAIT.
- Any illegal state encoding recovers to IDLE on the next edge.

## Timing
- Reset values: all of the following are 0, and the FIFO is empty.
  - `req_ready_o = 0` during reset; it reads 1 on the first cycle after reset deasserts.
  - `core_valid_o`, `core_a_o`, `core_b_o`, `res_valid_o`, `res_gcd_o`, `res_bypass_o`.
- Push at edge N: the request is at the FIFO head after edge N. IDLE pops at edge N+1. `core_valid_o` is high in cycle N+1..N+2.
- `core_valid_i` high in cycle M: `res_valid_o` is high from the cycle after edge M.
- Bypass latency: 2 edges from push to `res_valid_o`.
- The core returns to IDLE one cycle after its DONE, and RESP lasts ≥ 1 cycle. The next ISSUE therefore never reaches a busy core.
- Back-pressure: with `res_ready_i = 0`, the FSM stays in RESP and the FIFO keeps accepting requests until it is full.
- Reset asserted mid-operation (any state) returns everything to the reset values on that edge. The in-flight request and FIFO contents are discarded. The core shares `rst_i` and is reset as well.

## Configuration
- `GCD_DISPATCH_STATS_EN` defined:
  - Adds output port `stat_done_o`, 16 bits.
  - It counts result handshakes (`res_valid_o && res_ready_i`), bypass results included.
  - Reset value is 0; it wraps from 0xFFFF to 0x0000.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Single request (18,12), `res_ready_i = 1` -> exactly one `core_valid_o` pulse, `core_a_o`/`core_b_o` = 18/12 through ISSUE/WAIT, then `res_gcd_o = 6`, `res_bypass_o = 0`, one `res_valid_o` cycle.
- Zero bypass: (0,9) -> `res_gcd_o = 9`; (7,0) -> 7; (0,0) -> 0. All have `res_bypass_o = 1` and no `core_valid_o` pulse.
- Fill: push 5 requests back-to-back with `DEPTH = 4` and `res_ready_i = 0` -> `req_ready_o` drops once 4 are buffered plus 1 in flight. Then release `res_ready_i` -> results 2, 3, 6, 1, 5 for (6,2), (9,12), (18,12), (7,5), (5,5), in order.
- Back-pressure: hold `res_ready_i = 0` for 10 cycles in RESP -> `res_gcd_o` stable and `core_valid_o` low; the result is consumed on the first `res_ready_i = 1`.
- Reset mid-WAIT on (255,1) -> all outputs at reset values the next cycle and the FIFO empty. A new (9,12) afterwards yields 3.
- With `GCD_DISPATCH_STATS_EN`: preload the counter to 0xFFFE via 2 fewer handshakes than needed for a wrap (or force), complete 3 results -> `stat_done_o` reads 0xFFFF, then 0x0000, then 0x0001.
